bird_ctrl: RTL and testbench

Vertical-motion controller for the bird sprite. It consumes the one-cycle `tick` strobe from the frame-rate tick counter and the one-cycle `flap` pulse from the debounced key path, and keeps the bird's row on the LED matrix: rise on flap, fall under gravity, die on ground or pipe hit. Its outputs drive the display composer and the game-over logic.

---
 rtl/bird_ctrl.sv | 114 +++++++++++
 tb/tb_bird_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bird_ctrl.sv
// Vertical-motion controller for the bird sprite on the LED matrix.
// Rises on flap, falls on tick under gravity, dies on ground or pipe hit.
module bird_ctrl #(
    parameter int ROWS      = 8,
    parameter int START_ROW = 4,
    parameter int RISE_ROWS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    flap,
    input  logic                    hit,
    input  logic                    restart,
    output logic [$clog2(ROWS)-1:0] pos,
    output logic                    moved,
    output logic                    flying,
    output logic                    dead
);

    localparam int PW = $clog2(ROWS);
    localparam int RW = $clog2(RISE_ROWS + 1);

    localparam logic [PW-1:0] START = PW'(START_ROW);
    localparam logic [PW-1:0] GROUND = PW'(ROWS - 1);
    localparam logic [RW-1:0] RLOAD = RW'(RISE_ROWS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2,
        DEAD = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] pos_n;
    logic [RW-1:0] rcnt, rcnt_n;
    logic          flying_n, dead_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pos    <= START;
            rcnt   <= '0;
            moved  <= 1'b0;
            flying <= 1'b0;
            dead   <= 1'b0;
        end else begin
            state  <= state_n;
            pos    <= pos_n;
            rcnt   <= rcnt_n;
            moved  <= (pos_n != pos);
            flying <= flying_n;
            dead   <= dead_n;
        end
    end

    // hit outranks flap and tick; in FALL a flap discards a coincident tick
    always_comb begin
        state_n = state;
        pos_n   = pos;
        rcnt_n  = rcnt;
        unique case (state)
            IDLE: begin
                pos_n = START;
                if (flap) begin
                    state_n = RISE;
                    rcnt_n  = RLOAD;
                end
            end
            RISE: begin
                if (hit) begin
                    state_n = DEAD;
                end else if (tick) begin
                    pos_n = (pos == '0) ? '0 : pos - 1'b1;
                    if (flap) begin
                        rcnt_n = RLOAD;
                    end else begin
                        rcnt_n = (rcnt == '0) ? '0 : rcnt - 1'b1;
                        if (rcnt <= RW'(1))
                            state_n = FALL;
                    end
                end else if (flap) begin
                    rcnt_n = RLOAD;
                end
            end
            FALL: begin
                if (hit) begin
                    state_n = DEAD;
                end else if (flap) begin
                    state_n = RISE;
                    rcnt_n  = RLOAD;
                end else if (tick) begin
                    if (pos == GROUND)
                        state_n = DEAD;
                    else
                        pos_n = pos + 1'b1;
                end
            end
            DEAD: begin
                if (restart) begin
                    state_n = IDLE;
                    pos_n   = START;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        flying_n = (state_n == RISE) || (state_n == FALL);
        dead_n   = (state_n == DEAD);
    end

endmodule

// File: tb/tb_bird_ctrl.sv
// Directed testbench for bird_ctrl with ROWS=8, START_ROW=4, RISE_ROWS=2.
// Inputs change 1ns after posedge; outputs are checked at the same point.
module tb_bird_ctrl;

    logic       clk = 1'b0;
    logic       reset, tick, flap, hit, restart;
    logic [2:0] pos;
    logic       moved, flying, dead;

    int checks = 0;
    int failures = 0;

    bird_ctrl #(.ROWS(8), .START_ROW(4), .RISE_ROWS(2)) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .flap(flap),
        .hit(hit),
        .restart(restart),
        .pos(pos),
        .moved(moved),
        .flying(flying),
        .dead(dead)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // outputs: pos, moved, flying, dead
    task automatic st(input string tag, input int p, input int m, input int f, input int d);
        chk({tag, ".pos"}, int'(pos), p);
        chk({tag, ".moved"}, int'(moved), m);
        chk({tag, ".flying"}, int'(flying), f);
        chk({tag, ".dead"}, int'(dead), d);
    endtask

    task automatic cyc(input logic f, input logic t, input logic h, input logic r, input logic rs);
        flap = f; tick = t; hit = h; restart = r; reset = rs;
        @(posedge clk);
        #1;
        flap = 0; tick = 0; hit = 0; restart = 0; reset = 0;
    endtask

    initial begin
        flap = 0; tick = 0; hit = 0; restart = 0; reset = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 0;
        st("reset", 4, 0, 0, 0);

        // idle hold, also hit/restart ignored in IDLE
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 0, 0);
            st("idle_tick", 4, 0, 0, 0);
        end
        cyc(0, 1, 1, 1, 0);
        st("idle_hit", 4, 0, 0, 0);

        // flap arc
        cyc(1, 0, 0, 0, 0);
        st("arc_flap", 4, 0, 1, 0);
        chk("arc_flap.rcnt", int'(dut.rcnt), 2);
        cyc(0, 1, 0, 0, 0);
        st("arc_t1", 3, 1, 1, 0);
        chk("arc_t1.rcnt", int'(dut.rcnt), 1);
        cyc(0, 0, 0, 0, 0);
        st("arc_gap", 3, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        st("arc_t2", 2, 1, 1, 0);
        chk("arc_t2.rcnt", int'(dut.rcnt), 0);
        cyc(0, 1, 0, 0, 0);
        st("arc_t3", 3, 1, 1, 0);

        // ground death
        cyc(0, 1, 0, 0, 0);
        st("gnd_4", 4, 1, 1, 0);
        cyc(0, 1, 0, 0, 0);
        st("gnd_5", 5, 1, 1, 0);
        cyc(0, 1, 0, 0, 0);
        st("gnd_6", 6, 1, 1, 0);
        cyc(0, 1, 0, 0, 0);
        st("gnd_7", 7, 1, 1, 0);
        cyc(0, 1, 0, 0, 0);
        st("gnd_die", 7, 0, 0, 1);
        cyc(1, 1, 0, 0, 0);
        st("dead_frozen", 7, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        st("restart", 4, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        st("restart_after", 4, 0, 0, 0);

        // ceiling clamp
        cyc(1, 0, 0, 0, 0);
        st("ceil_flap", 4, 0, 1, 0);
        cyc(1, 1, 0, 0, 0);
        st("ceil_1", 3, 1, 1, 0);
        cyc(1, 1, 0, 0, 0);
        st("ceil_2", 2, 1, 1, 0);
        cyc(1, 1, 0, 0, 0);
        st("ceil_3", 1, 1, 1, 0);
        cyc(1, 1, 0, 0, 0);
        st("ceil_4", 0, 1, 1, 0);
        cyc(1, 1, 0, 0, 0);
        st("ceil_5", 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0);
        st("ceil_6", 0, 0, 1, 0);
        chk("ceil_6.rcnt", int'(dut.rcnt), 2);
        cyc(0, 1, 0, 0, 0);
        st("ceil_t1", 0, 0, 1, 0);
        chk("ceil_t1.rcnt", int'(dut.rcnt), 1);
        cyc(0, 1, 0, 0, 0);
        st("ceil_t2", 0, 0, 1, 0);
        chk("ceil_t2.rcnt", int'(dut.rcnt), 0);
        cyc(0, 1, 0, 0, 0);
        st("ceil_fall", 1, 1, 1, 0);

        // fall to pos 5, then flap+tick in FALL
        for (int i = 2; i <= 5; i++) begin
            cyc(0, 1, 0, 0, 0);
            st("fall_to5", i, 1, 1, 0);
        end
        cyc(1, 1, 0, 0, 0);
        st("fall_flaptick", 5, 0, 1, 0);
        chk("fall_flaptick.rcnt", int'(dut.rcnt), 2);
        cyc(1, 1, 0, 0, 0);
        st("rise_flaptick", 4, 1, 1, 0);
        chk("rise_flaptick.rcnt", int'(dut.rcnt), 2);
        cyc(0, 1, 0, 0, 0);
        st("rise_t1", 3, 1, 1, 0);
        cyc(0, 1, 0, 0, 0);
        st("rise_t2", 2, 1, 1, 0);
        cyc(1, 1, 1, 0, 0);
        st("fall_hit", 2, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        st("restart2", 4, 1, 0, 0);

        // hit in RISE
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0);
        st("rise_hit", 4, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        st("restart3", 4, 0, 0, 0);

        // reset mid-operation at pos 2, rcnt 1
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        st("pre_reset", 2, 1, 1, 0);
        chk("pre_reset.rcnt", int'(dut.rcnt), 1);
        cyc(0, 1, 0, 0, 1);
        st("mid_reset", 4, 0, 0, 0);
        chk("mid_reset.rcnt", int'(dut.rcnt), 0);
        cyc(0, 1, 0, 0, 0);
        st("post_reset_idle", 4, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
